fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch controller for the pipelined LEGv8 core. It owns the program counter, drives the word address of the 64-entry combinational instruction ROM, and registers the fetched word into the IF/ID pipeline register. It handles three control events from the rest of the pipeline: a stall from the hazard unit, a taken-branch redirect with IF/ID flush, and halt detection on the self-looping `CBZ XZR, #0` terminator.

## Interface
- `N`, 64: PC and branch-target width.
- `I`, 32: instruction width.
- `AW`, 6: instruction-memory word-address width (64 words).
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall_i` in 1: hazard unit requests PC and IF/ID hold.
- `br_taken_i` in 1: taken branch resolved downstream this cycle.
- `br_target_i` in N: byte address of branch target.
- `imem_addr_o` out AW: ROM word address, equal to `pc_o[AW+1:2]`.
- `imem_q_i` in I: ROM read data, combinational from `imem_addr_o`.
- `pc_o` out N: current fetch PC.
- `ifid_pc_o` out N: PC of the instruction held in IF/ID.
- `ifid_instr_o` out I: instruction held in IF/ID.
- `ifid_valid_o` out 1: IF/ID holds a real instruction; 0 means bubble.
- `halted_o` out 1: fetch has stopped on the halt word.
- `fetch_cnt_o` out 16: count of valid IF/ID loads, saturating at 0xFFFF.

## Operation
- Reset and clk/reset behaviour is as decided: one clock; reset is synchronous and active-high.
- FSM has two states, RUN and HALT. Reset state is RUN.
- Event priority per edge, highest first: reset > `br_taken_i` > `stall_i` > halt detect > normal fetch.
- **Reset.** Next-edge values:
  - `pc_o` = 0, `ifid_pc_o` = 0, `ifid_instr_o` = 0, `ifid_valid_o` = 0.
  - `halted_o` = 0, `fetch_cnt_o` = 0, state RUN.
- **Normal (RUN).**
  - IF/ID loads `{pc_o, imem_q_i, valid=1}`.
  - PC advances to PC+4.
  - `fetch_cnt_o` increments unless it is already 0xFFFF.
- **Stall.** PC, IF/ID, counter and state all hold. Stall has no effect in HALT.
- **Branch.**
  - PC loads `br_target_i` with bits [1:0] forced to 0.
  - IF/ID is flushed: instr = 0, valid = 0, `ifid_pc_o` = 0.
  - State goes to RUN and `halted_o` clears.
  - A branch overrides a simultaneous stall or halt detect.
- **Halt detect.** Triggers in RUN when `imem_q_i` equals HALT_WORD (32'hB400001F) and there is no branch and no stall.
  - IF/ID loads the halt word with valid = 1, and the counter increments.
  - PC holds at the halt word's address.
  - State goes to HALT and `halted_o` = 1.
- **HALT.**
  - Each edge loads a bubble into IF/ID (valid = 0, instr = 0). PC holds and the counter holds.
  - Only reset or `br_taken_i` leaves HALT. This covers a halt word fetched in the shadow of an older taken branch.
- **Arithmetic.**
  - PC+4 is N-bit modulo.
  - The ROM address is PC[AW+1:2], so fetch wraps: 0xFC → 0x100 fetches word 0 again.
  - Upper PC bits are kept, not truncated.

## Timing
- Fetch latency is 1 cycle. The word at `pc_o` in cycle t appears on `ifid_instr_o` after edge t.
- Branch penalty: the IF/ID bubble appears after edge t. The target word reaches IF/ID after edge t+1.
- `imem_addr_o` is purely combinational from the PC register. There is no ROM-side handshake.
- `halted_o` rises on the same edge that the halt word enters IF/ID.
- All outputs are registered except `imem_addr_o`.

## Structure
- Shared package `fetch_pkg`:
  - `HALT_WORD` = 32'hB400001F.
  - `NOP_WORD` = 32'h0.
  - Enum `fetch_state_t {RUN, HALT}`.
  - Width constants N, I, AW.
- Sub-module `ifid_reg`: IF/ID register with load, flush and hold controls, plus the valid bit. It is instantiated once.
- `fetch_unit` contains the PC register, next-PC mux, FSM and counter.
- The ROM stays outside the block and is connected at core top.

## Test plan
- **Reset then run.** ROM[0] = F8000001, ROM[1] = F8008002, release reset.
  - Edge 1: IF/ID = {0, F8000001, 1}, `pc_o` = 4.
  - Edge 2: IF/ID = {4, F8008002, 1}, `fetch_cnt_o` = 2.
- **Stall.** Hold `stall_i` for 3 cycles at PC = 8.
  - `pc_o` stays 8, IF/ID and counter unchanged.
  - On release, the next edge loads ROM[2] = F8000203.
- **Branch beats stall.** Assert `br_taken_i`, `stall_i`, `br_target_i` = 0x17 together.
  - Next edge: PC = 0x14, IF/ID valid = 0.
  - Following edge: IF/ID = {0x14, CB050083, 1}.
- **Halt.** Fetch reaches B400001F at PC = 0xD0.
  - `halted_o` = 1, IF/ID = {0xD0, B400001F, 1}.
  - Thereafter: `pc_o` = 0xD0, valid = 0, counter frozen.
  - A branch to 0x9C then clears `halted_o` and fetch resumes from 0x9C.
- **Wrap.** Force branch to 0xFC and run two edges.
  - `imem_addr_o` goes 63 → 0, `pc_o` = 0x100.
  - IF/ID holds ROM[63], then ROM[0] with `ifid_pc_o` = 0x100.
- **Reset mid-operation.** Assert reset while in HALT with `fetch_cnt_o` = 40 and a pending branch.
  - Next edge: all outputs return to reset values and the branch is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the LEGv8 instruction-fetch block.
//   N         - PC / branch-target width
//   I         - instruction width
//   AW        - instruction-ROM word-address width
//   HALT_WORD - encoding of the self-looping terminator CBZ XZR, #0
//   NOP_WORD  - value loaded into IF/ID for a bubble
//   CNT_MAX   - saturation value of the fetch counter
package fetch_pkg;

  localparam int N  = 64;
  localparam int I  = 32;
  localparam int AW = 6;

  localparam logic [31:0] HALT_WORD = 32'hB400001F;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with valid bit.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   load_i            - capture {pc_i, instr_i} as a valid instruction
//   flush_i           - insert a bubble (pc=0, instr=NOP, valid=0); wins over load_i
//   pc_i, instr_i     - PC and instruction word being fetched
//   pc_o, instr_o     - registered PC / instruction
//   valid_o           - 1 when the register holds a real instruction
// With neither load_i nor flush_i the contents hold (stall).
module ifid_reg #(
  parameter int N = 64,
  parameter int I = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic [N-1:0] pc_i,
  input  logic [I-1:0] instr_i,
  output logic [N-1:0] pc_o,
  output logic [I-1:0] instr_o,
  output logic         valid_o
);
  import fetch_pkg::*;

  logic [N-1:0] pc_q, pc_d;
  logic [I-1:0] instr_q, instr_d;
  logic         valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      instr_d = I'(NOP_WORD);
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  // IF/ID stage boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch controller for the pipelined LEGv8 core.
// Owns the PC, addresses the external combinational instruction ROM and
// registers the fetched word into IF/ID.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   stall_i         - hold PC, IF/ID and counter (ignored while halted)
//   br_taken_i      - taken branch: redirect PC and flush IF/ID
//   br_target_i     - branch byte address (bits [1:0] are ignored)
//   imem_addr_o     - ROM word address, pc_o[AW+1:2] (combinational)
//   imem_q_i        - ROM read data for imem_addr_o
//   pc_o            - current fetch PC
//   ifid_pc_o       - PC of the IF/ID instruction
//   ifid_instr_o    - IF/ID instruction
//   ifid_valid_o    - IF/ID holds a real instruction
//   halted_o        - fetch stopped on the halt word
//   fetch_cnt_o     - number of valid IF/ID loads, saturating at 0xFFFF
// Edge priority: reset > branch > (halted: bubble) > stall > halt detect > fetch.
module fetch_unit #(
  parameter int N  = fetch_pkg::N,
  parameter int I  = fetch_pkg::I,
  parameter int AW = fetch_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall_i,
  input  logic          br_taken_i,
  input  logic [N-1:0]  br_target_i,
  output logic [AW-1:0] imem_addr_o,
  input  logic [I-1:0]  imem_q_i,
  output logic [N-1:0]  pc_o,
  output logic [N-1:0]  ifid_pc_o,
  output logic [I-1:0]  ifid_instr_o,
  output logic          ifid_valid_o,
  output logic          halted_o,
  output logic [15:0]   fetch_cnt_o
);
  import fetch_pkg::*;

  localparam logic [N-1:0] PC_STEP = N'(4);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         ifid_load, ifid_flush;
  logic         halt_det;

  // Only a word fetched while running can trigger the halt transition.
  assign halt_det = (state_q == RUN) && (imem_q_i == I'(HALT_WORD));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    if (br_taken_i) begin
      // Redirect is word-aligned; IF/ID gets a bubble and any halt is lifted.
      pc_d       = {br_target_i[N-1:2], 2'b00};
      ifid_flush = 1'b1;
      state_d    = RUN;
    end else if (state_q == HALT) begin
      // Halted fetch keeps feeding bubbles even under stall.
      ifid_flush = 1'b1;
    end else if (stall_i) begin
      // Everything holds.
    end else if (halt_det) begin
      // Halt word itself is a real instruction; PC parks on it.
      ifid_load = 1'b1;
      cnt_d     = sat_inc(cnt_q);
      state_d   = HALT;
    end else begin
      ifid_load = 1'b1;
      cnt_d     = sat_inc(cnt_q);
      pc_d      = pc_q + PC_STEP;
    end
  end

  // IF stage boundary: PC, FSM and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  ifid_reg #(
    .N (N),
    .I (I)
  ) u_ifid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .instr_i (imem_q_i),
    .pc_o    (ifid_pc_o),
    .instr_o (ifid_instr_o),
    .valid_o (ifid_valid_o)
  );

  assign imem_addr_o = pc_q[AW+1:2];
  assign pc_o        = pc_q;
  assign halted_o    = (state_q == HALT);
  assign fetch_cnt_o = cnt_q;

endmodule
